// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative multiply/divide unit for the EX stage.
// Processes one operand bit per clock. It handles signed and unsigned
// multiply (shift-add) and divide (restoring). It also supports an annul
// (flush) input and detects divide-by-zero.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start_i     request a new operation (sampled only in IDLE)
//   op_i        00=multu 01=mult 10=divu 11=div
//   opdata1_i   multiplicand / dividend
//   opdata2_i   multiplier / divisor
//   annul_i     abort the in-flight operation
//   busy_o      high while iterating or applying the sign fix-up
//   ready_o     one-cycle pulse; result_o and div_zero_o are valid
//   result_o    mul: {hi,lo} product; div: {remainder,quotient}
//   div_zero_o  set with ready_o when a divide had a zero divisor
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Magnitude of a two's-complement operand. The result is returned as
  // unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    if (v < 0) return $unsigned(-v);
    else       return $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
    return -v;
  endfunction

  logic signed [WIDTH-1:0] opa_s, opb_s;
  logic [WIDTH-1:0]        opa_mag, opb_mag;
  logic                    accept;
  logic                    div_by_zero;

  // Operation state captured at accept time
  logic [1:0]              op_p0;
  logic                    neg_quot_p0;
  logic                    neg_rem_p0;
  logic [WIDTH-1:0]        operand_p0;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]      work_p0;      // {hi,lo} product or {rem,quot}
  logic [CNT_W-1:0]        cnt_p0;

  assign opa_s   = opdata1_i;
  assign opb_s   = opdata2_i;
  assign opa_mag = op_i[0] ? abs_val(opa_s) : opdata1_i;
  assign opb_mag = op_i[0] ? abs_val(opb_s) : opdata2_i;

  assign accept      = (state_q == S_IDLE) && start_i && !annul_i;
  assign div_by_zero = op_i[1] && (opdata2_i == '0);

  assign busy_o  = (state_q == S_CALC) || (state_q == S_FIX);
  assign ready_o = (state_q == S_DONE);

  // ---- control FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = div_by_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (annul_i)                  state_d = S_IDLE;
        else if (cnt_p0 == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = annul_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- one iteration step
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_addend = work_p0[0] ? operand_p0 : '0;
    // The carry out of the upper-half add becomes the top bit after the shift
    mul_sum    = {1'b0, work_p0[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, work_p0[WIDTH-1:1]};

    // The partial remainder stays below the divisor, so the shifted value
    // fits in WIDTH+1 bits. A trial difference that fits always fits in WIDTH bits.
    div_shift  = {work_p0[2*WIDTH-1:WIDTH], work_p0[WIDTH-1]};
    div_trial  = div_shift - {1'b0, operand_p0};
    div_fits   = (div_shift >= {1'b0, operand_p0});
    div_next   = div_fits ? {div_trial[WIDTH-1:0], work_p0[WIDTH-2:0], 1'b1}
                          : {div_shift[WIDTH-1:0], work_p0[WIDTH-2:0], 1'b0};
  end

  // ---- sign fix-up
  logic [2*WIDTH-1:0] fix_result;
  logic [WIDTH-1:0]   fix_rem, fix_quot;

  always_comb begin
    fix_rem  = neg_rem_p0  ? negate_w(work_p0[2*WIDTH-1:WIDTH]) : work_p0[2*WIDTH-1:WIDTH];
    fix_quot = neg_quot_p0 ? negate_w(work_p0[WIDTH-1:0])       : work_p0[WIDTH-1:0];
    case (op_p0)
      2'b01:   fix_result = neg_quot_p0 ? negate_2w(work_p0) : work_p0;
      2'b11:   fix_result = {fix_rem, fix_quot};
      default: fix_result = work_p0;
    endcase
  end

  // ---- datapath registers (no reset; only meaningful after accept)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0       <= op_i;
      neg_quot_p0 <= op_i[0] & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
      neg_rem_p0  <= op_i[0] & opdata1_i[WIDTH-1];
      cnt_p0      <= CNT_W'(WIDTH);
      if (op_i[1]) begin
        operand_p0 <= opb_mag;
        work_p0    <= {{WIDTH{1'b0}}, opa_mag};
      end else begin
        operand_p0 <= opa_mag;
        work_p0    <= {{WIDTH{1'b0}}, opb_mag};
      end
    end else if (state_q == S_CALC) begin
      cnt_p0  <= cnt_p0 - CNT_W'(1);
      work_p0 <= op_p0[1] ? div_next : mul_next;
    end
  end

  // ---- result and divide-by-zero flag, held until the next update
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o   <= '0;
      div_zero_o <= 1'b0;
    end else if (accept) begin
      div_zero_o <= div_by_zero;
      if (div_by_zero) result_o <= {opdata1_i, {WIDTH{1'b1}}};
    end else if ((state_q == S_FIX) && !annul_i) begin
      result_o <= fix_result;
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
module tb_iter_muldiv;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;
  logic        div_zero_o;

  iter_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t        vecs[14];
  int          n_tests;
  int          n_fail;
  logic [63:0] last_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a start for one edge; returns in cycle 1 (posedge + 1)
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Called in cycle 1; follows the operation until ready_o (bounded)
  task automatic wait_ready(input string name, input logic [63:0] er, input logic edz, input int elat);
    int          lat;
    int          busy_err;
    logic [63:0] got_res;
    logic        got_dz;
    lat      = 0;
    busy_err = 0;
    got_res  = 'x;
    got_dz   = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy_o !== ((c < elat) ? 1'b1 : 1'b0)) busy_err++;
      if (ready_o === 1'b1) begin
        lat     = c;
        got_res = result_o;
        got_dz  = div_zero_o;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({name, "_latency"}, 64'(lat), 64'(elat));
    check({name, "_result"}, got_res, er);
    check({name, "_divzero"}, {63'd0, got_dz}, {63'd0, edz});
    check({name, "_busy_profile"}, 64'(busy_err), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, "_ready_pulse_width"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    start_i   = 1'b0;
    op_i      = 2'b00;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i   = 1'b0;

    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 1'b0, 34};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 34};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
    vecs[3]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 34};
    vecs[4]  = '{DIVU,  32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1, 1};
    vecs[5]  = '{MULTU, 32'h12345678, 32'h10,       64'h00000001_23456780, 1'b0, 34};
    vecs[6]  = '{MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 34};
    vecs[7]  = '{MULT,  32'd5,        32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFB, 1'b0, 34};
    vecs[8]  = '{DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 34};
    vecs[9]  = '{DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 34};
    vecs[10] = '{DIVU,  32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 1'b0, 34};
    vecs[11] = '{MULT,  32'd0,        32'hFFFFFFFF, 64'h00000000_00000000, 1'b0, 34};
    vecs[12] = '{DIVU,  32'd3,        32'd10,       64'h00000003_00000000, 1'b0, 34};
    vecs[13] = '{DIV,   32'hFFFFFFF8, 32'd0,        64'hFFFFFFF8_FFFFFFFF, 1'b1, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",    {63'd0, busy_o},     64'd0);
    check("reset_ready",   {63'd0, ready_o},    64'd0);
    check("reset_divzero", {63'd0, div_zero_o}, 64'd0);
    check("reset_result",  result_o,            64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_ready($sformatf("vec%0d", i), vecs[i].res, vecs[i].dz, vecs[i].lat);
      @(posedge clk);
      #1;
    end
    last_res = vecs[13].res;

    // start together with annul in IDLE is ignored (a divide by zero would pulse at once)
    start_i   = 1'b1;
    annul_i   = 1'b1;
    op_i      = DIVU;
    opdata1_i = 32'd9;
    opdata2_i = 32'd0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);
    check("idle_annul_ready",   {63'd0, ready_o},    64'd0);
    check("idle_annul_busy",    {63'd0, busy_o},     64'd0);
    check("idle_annul_result",  result_o,            last_res);
    check("idle_annul_divzero", {63'd0, div_zero_o}, 64'd1);
    @(posedge clk);
    #1;

    // Annul in CALC: divu 100/7, annul during cycle 10
    start_op(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    check("annul_calc_busy",    {63'd0, busy_o},     64'd0);
    check("annul_calc_ready",   {63'd0, ready_o},    64'd0);
    check("annul_calc_result",  result_o,            last_res);
    check("annul_calc_divzero", {63'd0, div_zero_o}, 64'd0);
    // Restart in the very next cycle
    start_op(DIVU, 32'd100, 32'd7);
    wait_ready("restart_after_annul", 64'h00000002_0000000E, 1'b0, 34);
    last_res = 64'h00000002_0000000E;
    @(posedge clk);
    #1;

    // Annul in FIX: no pulse ever, result unchanged
    start_op(MULTU, 32'd3, 32'd3);
    repeat (32) @(posedge clk);
    #1;
    check("fix_state_busy", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (ready_o === 1'b1 || busy_o === 1'b1) pulses++;
      end
      check("annul_fix_no_activity", 64'(pulses), 64'd0);
    end
    check("annul_fix_result", result_o, last_res);
    @(posedge clk);
    #1;

    // Annul in DONE: pulse still occurs
    start_op(MULT, 32'd6, 32'd7);
    repeat (33) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_done_ready",  {63'd0, ready_o}, 64'd1);
    check("annul_done_result", result_o,         64'd42);
    check("annul_done_busy",   {63'd0, busy_o},  64'd0);
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    @(negedge clk);
    check("annul_done_after", {63'd0, ready_o}, 64'd0);
    @(posedge clk);
    #1;

    // Divide by zero leaves a flag, then reset during a mult clears everything
    start_op(DIVU, 32'd1, 32'd0);
    wait_ready("dz_before_reset", 64'h00000001_FFFFFFFF, 1'b1, 1);
    @(posedge clk);
    #1;
    start_op(MULT, 32'hFFFFFFFD, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy",    {63'd0, busy_o},     64'd0);
    check("midrst_ready",   {63'd0, ready_o},    64'd0);
    check("midrst_divzero", {63'd0, div_zero_o}, 64'd0);
    check("midrst_result",  result_o,            64'd0);
    start_op(MULT, 32'hFFFFFFFD, 32'd7);
    wait_ready("after_reset", 64'hFFFFFFFF_FFFFFFEB, 1'b0, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
